// File: rtl/wb_gpio.sv
`default_nettype none
// ============================================================================
// Module      : wb_gpio
// Description : Wishbone B4 pipelined GPIO slave with pad synchroniser,
//               edge detection and a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_gpio #(
    parameter int N_GPIO      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              wb_stall_o,
    input  logic [N_GPIO-1:0] gpio_i,
    output logic [N_GPIO-1:0] gpio_o,
    output logic [N_GPIO-1:0] gpio_oe_o,
    output logic              irq_o
);

    localparam logic [3:0] c_DIN   = 4'h0;
    localparam logic [3:0] c_DOUT  = 4'h1;
    localparam logic [3:0] c_DIR   = 4'h2;
    localparam logic [3:0] c_SET   = 4'h3;
    localparam logic [3:0] c_CLR   = 4'h4;
    localparam logic [3:0] c_TGL   = 4'h5;
    localparam logic [3:0] c_IEN   = 4'h6;
    localparam logic [3:0] c_IPOL  = 4'h7;
    localparam logic [3:0] c_IBOTH = 4'h8;
    localparam logic [3:0] c_ISTAT = 4'h9;

    logic [SYNC_STAGES-1:0][N_GPIO-1:0] sync_q;
    logic [N_GPIO-1:0] prev_q;
    logic [N_GPIO-1:0] dout_q, dout_d;
    logic [N_GPIO-1:0] dir_q, dir_d;
    logic [N_GPIO-1:0] ien_q, ien_d;
    logic [N_GPIO-1:0] ipol_q, ipol_d;
    logic [N_GPIO-1:0] iboth_q, iboth_d;
    logic [N_GPIO-1:0] istat_q, istat_d;
    logic [N_GPIO-1:0] w1c_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              irq_q;
    logic [31:0]       dat_q, dat_d;

    logic              w_accept;
    logic [3:0]        w_idx;
    logic              w_hit;
    logic [31:0]       w_lanes;
    logic [N_GPIO-1:0] w_mask;
    logic [N_GPIO-1:0] w_wdat;
    logic [N_GPIO-1:0] w_din;
    logic [N_GPIO-1:0] w_event;
    logic              w_unused;

    assign w_accept = wb_cyc_i & wb_stb_i;
    assign w_idx    = wb_adr_i[5:2];
    assign w_hit    = (w_idx <= c_ISTAT);
    assign w_lanes  = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign w_mask   = w_lanes[N_GPIO-1:0];
    assign w_wdat   = wb_dat_i[N_GPIO-1:0] & w_mask;
    assign w_din    = sync_q[SYNC_STAGES-1];
    assign w_unused = ^{wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i, w_lanes};

    // IBOTH takes precedence; otherwise IPOL picks rising (1) or falling (0)
    assign w_event = (iboth_q & (w_din ^ prev_q))
                   | (~iboth_q &  ipol_q &  w_din & ~prev_q)
                   | (~iboth_q & ~ipol_q & ~w_din &  prev_q);

    always_comb begin
        dout_d  = dout_q;
        dir_d   = dir_q;
        ien_d   = ien_q;
        ipol_d  = ipol_q;
        iboth_d = iboth_q;
        w1c_d   = '0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = '0;
        if (w_accept) begin
            if (!w_hit) begin
                err_d = 1'b1;
            end else begin
                ack_d = 1'b1;
                if (wb_we_i) begin
                    case (w_idx)
                        c_DOUT:  dout_d  = (dout_q  & ~w_mask) | w_wdat;
                        c_DIR:   dir_d   = (dir_q   & ~w_mask) | w_wdat;
                        c_SET:   dout_d  = dout_q | w_wdat;
                        c_CLR:   dout_d  = dout_q & ~w_wdat;
                        c_TGL:   dout_d  = dout_q ^ w_wdat;
                        c_IEN:   ien_d   = (ien_q   & ~w_mask) | w_wdat;
                        c_IPOL:  ipol_d  = (ipol_q  & ~w_mask) | w_wdat;
                        c_IBOTH: iboth_d = (iboth_q & ~w_mask) | w_wdat;
                        c_ISTAT: w1c_d   = w_wdat;
                        default: ;
                    endcase
                end else begin
                    case (w_idx)
                        c_DIN:   dat_d = 32'(w_din);
                        c_DOUT:  dat_d = 32'(dout_q);
                        c_DIR:   dat_d = 32'(dir_q);
                        c_IEN:   dat_d = 32'(ien_q);
                        c_IPOL:  dat_d = 32'(ipol_q);
                        c_IBOTH: dat_d = 32'(iboth_q);
                        c_ISTAT: dat_d = 32'(istat_q);
                        default: dat_d = '0;
                    endcase
                end
            end
        end
        // a fresh event wins over a simultaneous clear
        istat_d = (istat_q & ~w1c_d) | w_event;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            prev_q  <= '0;
            dout_q  <= '0;
            dir_q   <= '0;
            ien_q   <= '0;
            ipol_q  <= '0;
            iboth_q <= '0;
            istat_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], gpio_i};
            prev_q  <= w_din;
            dout_q  <= dout_d;
            dir_q   <= dir_d;
            ien_q   <= ien_d;
            ipol_q  <= ipol_d;
            iboth_q <= iboth_d;
            istat_q <= istat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            irq_q   <= |(istat_q & ien_q);
        end
    end

    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign wb_stall_o = 1'b0;
    assign gpio_o     = dout_q;
    assign gpio_oe_o  = dir_q;
    assign irq_o      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_gpio.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_gpio
// Description : Self-checking bench for wb_gpio: directed scenarios plus
//               randomized bus/pad traffic against a register-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_gpio;

    localparam int c_N = 32;
    localparam int c_S = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0]    adr = '0, wdat = '0;
    logic [3:0]     sel = 4'hF;
    logic [31:0]    dat_o;
    logic           ack_o, err_o, stall_o, irq;
    logic [c_N-1:0] gpio_in = '0;
    logic [c_N-1:0] gpio_out, gpio_oe;

    int checks = 0;
    int errors = 0;

    // model state: register file indexed by word offset, pad sample history
    logic [31:0] m_reg [10];
    logic [31:0] m_pad [c_S+1];
    logic        m_ack = 1'b0, m_err = 1'b0, m_irq = 1'b0;
    logic [31:0] m_dat = '0;

    always #5 clk = ~clk;

    wb_gpio #(.N_GPIO(c_N), .SYNC_STAGES(c_S)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_dat_o(dat_o), .wb_ack_o(ack_o), .wb_err_o(err_o), .wb_stall_o(stall_o),
        .gpio_i(gpio_in), .gpio_o(gpio_out), .gpio_oe_o(gpio_oe), .irq_o(irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 10; i++) m_reg[i] = '0;
        for (int i = 0; i <= c_S; i++) m_pad[i] = '0;
        m_ack = 1'b0; m_err = 1'b0; m_irq = 1'b0; m_dat = '0;
    endtask

    // what the register map should look like after this clock edge
    task automatic model_edge();
        logic [31:0] din, prev, evt, lanes, wd, w1c;
        logic        irq_next;
        int          idx;
        if (rst) begin
            model_clear();
            return;
        end
        din  = m_pad[c_S-1];
        prev = m_pad[c_S];
        evt  = '0;
        for (int b = 0; b < 32; b++) begin
            if (m_reg[8][b])      evt[b] = (din[b] != prev[b]);
            else if (m_reg[7][b]) evt[b] = din[b] && !prev[b];
            else                  evt[b] = !din[b] && prev[b];
        end
        irq_next = ((m_reg[9] & m_reg[6]) != 0);
        m_ack = 1'b0; m_err = 1'b0; m_dat = '0; w1c = '0;
        if (cyc && stb) begin
            idx = int'(adr[5:2]);
            if (idx > 9) begin
                m_err = 1'b1;
            end else begin
                m_ack = 1'b1;
                lanes = '0;
                for (int i = 0; i < 4; i++) if (sel[i]) lanes[i*8 +: 8] = 8'hFF;
                wd = wdat & lanes;
                if (we) begin
                    case (idx)
                        1, 2, 6, 7, 8: m_reg[idx] = (m_reg[idx] & ~lanes) | wd;
                        3: m_reg[1] = m_reg[1] | wd;
                        4: m_reg[1] = m_reg[1] & ~wd;
                        5: m_reg[1] = m_reg[1] ^ wd;
                        9: w1c = wd;
                        default: ;
                    endcase
                end else begin
                    if (idx == 0)               m_dat = din;
                    else if (idx >= 3 && idx <= 5) m_dat = '0;
                    else                        m_dat = m_reg[idx];
                end
            end
        end
        m_reg[9] = (m_reg[9] & ~w1c) | evt;
        for (int i = c_S; i > 0; i--) m_pad[i] = m_pad[i-1];
        m_pad[0] = gpio_in;
        m_irq = irq_next;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("ack",   32'(ack_o),  32'(m_ack));
        check_eq("err",   32'(err_o),  32'(m_err));
        check_eq("dat",   dat_o,       m_dat);
        check_eq("gpio_o", gpio_out,   m_reg[1]);
        check_eq("gpio_oe", gpio_oe,   m_reg[2]);
        check_eq("irq",   32'(irq),    32'(m_irq));
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
        tick();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        tick();
        d = dat_o;
        cyc = 1'b0; stb = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] pipe_adr [4];
        logic [31:0] pipe_exp [4];
        model_clear();

        // reset and read back every register
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_eq("stall", 32'(stall_o), 32'h0);
        for (int i = 0; i < 10; i++) begin
            bus_read(32'(i * 4), rd);
            check_eq("rst_read", rd, 32'h0);
            check_eq("rst_read_ack", 32'(ack_o), 32'h1);
        end
        bus_read(32'h0200_0028, rd);
        check_eq("hole_err", 32'(err_o), 32'h1);
        check_eq("hole_ack", 32'(ack_o), 32'h0);

        // output data path
        bus_write(32'h04, 32'h0000_00F0, 4'hF);
        bus_write(32'h0C, 32'h0000_000F, 4'hF);
        bus_write(32'h10, 32'h0000_0030, 4'hF);
        bus_write(32'h14, 32'h0000_0101, 4'hF);
        check_eq("dout_ops", gpio_out, 32'h0000_01CE);
        bus_write(32'h08, 32'h0000_FFFF, 4'b0001);
        check_eq("dir_sel", gpio_oe, 32'h0000_00FF);

        // rising-edge interrupt latency and W1C
        bus_write(32'h18, 32'h1, 4'hF);
        bus_write(32'h1C, 32'h1, 4'hF);
        gpio_in[0] = 1'b1;
        tick(); tick(); tick();
        check_eq("irq_before", 32'(irq), 32'h0);
        tick();
        check_eq("irq_rise", 32'(irq), 32'h1);
        bus_read(32'h24, rd);
        check_eq("istat_rise", rd, 32'h1);
        bus_write(32'h24, 32'h1, 4'hF);
        tick();
        check_eq("irq_w1c", 32'(irq), 32'h0);
        gpio_in[0] = 1'b0;
        repeat (5) tick();
        bus_read(32'h24, rd);
        check_eq("istat_fall_ignored", rd, 32'h0);

        // both-edge detection with interrupt disabled
        bus_write(32'h18, 32'h0, 4'hF);
        bus_write(32'h20, 32'h8, 4'hF);
        gpio_in[3] = 1'b1;
        tick(); tick(); tick();
        bus_read(32'h24, rd);
        check_eq("istat_both_rise", rd, 32'h8);
        bus_write(32'h24, 32'h8, 4'hF);
        gpio_in[3] = 1'b0;
        repeat (4) tick();
        bus_read(32'h24, rd);
        check_eq("istat_both_fall", rd, 32'h8);
        check_eq("irq_masked", 32'(irq), 32'h0);

        // event coinciding with W1C of the same bit
        bus_write(32'h1C, 32'h5, 4'hF);
        gpio_in[2] = 1'b1;
        tick(); tick();
        bus_write(32'h24, 32'h4, 4'hF);
        bus_read(32'h24, rd);
        check_eq("set_wins", rd, 32'hC);

        // pipelined reads, cycle abort, reset mid-burst
        pipe_adr = '{32'h04, 32'h08, 32'h1C, 32'h24};
        pipe_exp = '{32'h1CE, 32'hFF, 32'h5, 32'hC};
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            adr = pipe_adr[i];
            tick();
            check_eq("pipe_ack", 32'(ack_o), 32'h1);
            check_eq("pipe_dat", dat_o, pipe_exp[i]);
        end
        cyc = 1'b0;
        tick();
        check_eq("abort_ack", 32'(ack_o), 32'h0);
        cyc = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check_eq("rst_ack", 32'(ack_o), 32'h0);
        check_eq("rst_gpio", gpio_out, 32'h0);
        check_eq("rst_oe", gpio_oe, 32'h0);
        check_eq("rst_dat", dat_o, 32'h0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        tick();

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            rst  = ($urandom_range(0, 299) == 0);
            cyc  = ($urandom_range(0, 7) != 0);
            stb  = ($urandom_range(0, 9) < 6);
            we   = $urandom_range(0, 1) != 0;
            adr  = $urandom;
            wdat = $urandom;
            sel  = 4'($urandom);
            if ($urandom_range(0, 3) == 0) gpio_in[$urandom_range(0, c_N-1)] ^= 1'b1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_gpio.md
Name: wb_gpio

Overview:
Wishbone B4 pipelined slave GPIO port. It fills the gpioa slot on the SoC crossbar: base 0x02000000, mask 0xFFFFFFC0, giving a 64-byte window of 16 word registers.
- Drives pad outputs and output enables.
- Synchronises pad inputs.
- Detects input edges and raises a level interrupt toward the CPU irq vector.

Parameters:
N_GPIO, 32, number of implemented pins (1..32); register bits at or above N_GPIO read 0 and ignore writes.
SYNC_STAGES, 2, flip-flop stages on gpio_i before any use (>=2).

Ports:
- clk_i  in  1  bus clock.
- rst_i  in  1  synchronous active-high reset.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  32  byte address; only [5:2] decoded.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  access acknowledge.
- wb_err_o  out  1  error acknowledge.
- wb_stall_o  out  1  stall; tied 0.
- gpio_i  in  N_GPIO  pad inputs (asynchronous).
- gpio_o  out  N_GPIO  pad output values.
- gpio_oe_o  out  N_GPIO  output enables, 1 = drive.
- irq_o  out  1  level interrupt.

Behaviour:
Reset:
- All registers 0. gpio_o=0, gpio_oe_o=0, irq_o=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
- Synchroniser flops and edge-history register cleared to 0.

Bus handshake:
- A request is accepted when wb_cyc_i & wb_stb_i; wb_stall_o is always 0.
- Exactly one of wb_ack_o / wb_err_o pulses in the cycle after acceptance (1-cycle latency).
- Back-to-back accepts produce back-to-back acks.
- wb_dat_o is valid with the ack; it is 0 for writes and error responses.
- Dropping wb_cyc_i cancels the pending response: next cycle ack=err=0, and no register side effect is lost or replayed.
- Register write effects take place at the accept edge.

Register map (offset: name, access):
- 0x00 DIN (RO): synchronised inputs.
- 0x04 DOUT (RW).
- 0x08 DIR (RW): drives gpio_oe_o.
- 0x0C SET (WO): DOUT |= wdata.
- 0x10 CLR (WO): DOUT &= ~wdata.
- 0x14 TGL (WO): DOUT ^= wdata.
- 0x18 IEN (RW): irq enables.
- 0x1C IPOL (RW): 1 = rising edge, 0 = falling edge.
- 0x20 IBOTH (RW): 1 = both edges, overrides IPOL.
- 0x24 ISTAT (R/W1C).
- 0x28-0x3C: no register. The access returns wb_err_o and has no side effect.
- Write-only registers read 0.

Byte selects:
- RW writes and SET/CLR/TGL/ISTAT masks apply only to byte lanes with wb_sel_i set.
- A write with wb_sel_i=0 acks with no effect.

Outputs:
- gpio_o = DOUT and gpio_oe_o = DIR, both direct register outputs (no extra delay).

Input path:
- sync = SYNC_STAGES-deep shift of gpio_i. DIN = final stage.
- prev = DIN delayed by 1 cycle.
- Per bit, event = IBOTH ? (DIN ^ prev) : IPOL ? (DIN & ~prev) : (~DIN & prev).
- Events are detected regardless of IEN; IEN only gates irq_o.
- Latency: a pad change is visible in DIN after SYNC_STAGES edges and sets ISTAT one edge later.

ISTAT updates:
- Each cycle: ISTAT <= (ISTAT & ~w1c_mask) | event.
- A new event in the same cycle as a W1C of that bit leaves the bit set (set wins).
- irq_o is registered: irq_o <= |(ISTAT & IEN), reset 0. It deasserts the cycle after the status is cleared or the enable drops.
- The first cycle after reset produces no event, because prev and DIN are both 0 after reset.

Test Plan:
1. Reset, then read all 10 registers -> all return 0, each with a 1-cycle ack; a read of 0x28 returns wb_err_o=1 with wb_ack_o=0.
2. Write DOUT=0x0000_00F0, SET 0x0F, CLR 0x30, TGL 0x101 -> gpio_o=0x0000_01CE; write DIR=0xFFFF with sel=4'b0001 -> gpio_oe_o=0x0000_00FF.
3. IEN=1, IPOL=1, gpio_i[0] 0->1 -> ISTAT[0]=1 exactly 3 cycles after the pad edge and irq_o=1 one cycle later; a 1->0 transition sets nothing; W1C 0x1 -> irq_o=0 the next cycle.
4. IBOTH[3]=1, pulse gpio_i[3] high for 5 cycles -> both edges latch ISTAT[3]; with IEN=0, irq_o stays 0 and ISTAT still reads 0x8.
5. Drive a rising event on bit 2 in the same cycle as a W1C of bit 2 -> ISTAT[2] remains 1.
6. Issue 4 pipelined reads (stb held 4 cycles) -> 4 consecutive acks with the correct data; drop cyc mid-burst -> no ack the next cycle; assert rst_i mid-burst -> all outputs 0 the next cycle.
